// File: rtl/mac_seq_multiplier_if.sv
`default_nettype none
// ============================================================================
//  Module   : mac_seq_multiplier_if
//  Brief    : Start/busy/done handshake and operand/product bus of the
//             sequential MAC multiplier.
//  Revision : 1.0 - initial release
// ============================================================================
interface mac_seq_multiplier_if #(
  parameter int N = 32
);
  logic           start;
  logic [N-1:0]   multiplicand;
  logic [N-1:0]   multiplier;
  logic           busy;
  logic           done;
  logic [2*N-1:0] product;

  // Requester side (MAC controller)
  modport master (
    output start, multiplicand, multiplier,
    input  busy, done, product
  );

  // Multiplier side
  modport slave (
    input  start, multiplicand, multiplier,
    output busy, done, product
  );
endinterface
`default_nettype wire

// File: rtl/mac_seq_multiplier.sv
`default_nettype none
// ============================================================================
//  Module   : mac_seq_multiplier
//  Brief    : Radix-2 shift-and-add multiplier, N iterations per product,
//             2N-bit registered result with start/busy/done handshake.
//             Optional macro MAC_MULT_SIGNED_EN selects two's-complement
//             operands (magnitude iteration plus final sign fix-up).
//  Revision : 1.0 - initial release
// ============================================================================
module mac_seq_multiplier #(
  parameter int N = 32
) (
  input  wire logic           clk,
  input  wire logic           rst,
  mac_seq_multiplier_if.slave bus
);

  localparam int                 c_cnt_w     = (N > 1) ? $clog2(N) : 1;
  localparam logic [c_cnt_w-1:0] c_last_iter = c_cnt_w'(N - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_next;

  logic [N:0]         r_acc;      // upper half of P, one extra bit for carry
  logic [N-1:0]       r_mq;       // lower half of P, multiplier bits consumed from bit 0
  logic [N-1:0]       r_mcand;
  logic [c_cnt_w-1:0] r_count;
  logic [2*N-1:0]     r_product;

  logic               w_accept;
  logic               w_last;
  logic [N:0]         w_sum;
  logic [2*N-1:0]     w_p_shift;
  logic [N-1:0]       w_load_a;
  logic [N-1:0]       w_load_b;
  logic [2*N-1:0]     w_final;

  assign w_accept = (r_state == ST_IDLE) && bus.start;
  assign w_last   = (r_state == ST_RUN) && (r_count == c_last_iter);

  // Conditional add of the multiplicand, then the whole P register shifts right;
  // w_p_shift is the low 2N bits of P after this cycle's iteration.
  assign w_sum     = r_mq[0] ? ({1'b0, r_acc[N-1:0]} + {1'b0, r_mcand}) : r_acc;
  assign w_p_shift = {w_sum, r_mq[N-1:1]};

`ifdef MAC_MULT_SIGNED_EN
  logic r_sign;

  // Most-negative input maps to itself, which read unsigned is 2^(N-1).
  assign w_load_a = bus.multiplicand[N-1] ? (-bus.multiplicand) : bus.multiplicand;
  assign w_load_b = bus.multiplier[N-1]   ? (-bus.multiplier)   : bus.multiplier;
  assign w_final  = r_sign ? (-w_p_shift) : w_p_shift;

  // Result sign captured alongside the operand magnitudes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sign <= 1'b0;
    end else if (w_accept) begin
      r_sign <= bus.multiplicand[N-1] ^ bus.multiplier[N-1];
    end
  end
`else
  assign w_load_a = bus.multiplicand;
  assign w_load_b = bus.multiplier;
  assign w_final  = w_p_shift;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic: start only honoured in IDLE, DONE lasts one cycle
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (bus.start) w_state_next = ST_RUN;
      ST_RUN:  if (w_last)    w_state_next = ST_DONE;
      ST_DONE:                w_state_next = ST_IDLE;
      default:                w_state_next = ST_IDLE;
    endcase
  end

  // Operand capture, one shift-add iteration per RUN cycle, product load on exit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc     <= '0;
      r_mq      <= '0;
      r_mcand   <= '0;
      r_count   <= '0;
      r_product <= '0;
    end else if (w_accept) begin
      r_mcand <= w_load_a;
      r_mq    <= w_load_b;
      r_acc   <= '0;
      r_count <= '0;
    end else if (r_state == ST_RUN) begin
      r_acc   <= {1'b0, w_sum[N:1]};
      r_mq    <= {w_sum[0], r_mq[N-1:1]};
      r_count <= r_count + c_cnt_w'(1);
      if (w_last) begin
        r_product <= w_final;
      end
    end
  end

  assign bus.busy    = (r_state == ST_RUN);
  assign bus.done    = (r_state == ST_DONE);
  assign bus.product = r_product;

endmodule
`default_nettype wire

// File: tb/tb_mac_seq_multiplier.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mac_seq_multiplier
//  Brief    : Self-checking bench for mac_seq_multiplier: directed corner
//             cases plus randomized operands against an arithmetic model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mac_seq_multiplier;

  localparam int N = 32;

  logic clk;
  logic rst;

  int n_checks    = 0;
  int n_errors    = 0;
  int cycle_cnt   = 0;
  int done_pulses = 0;
  int last_done   = 0;
  logic [2*N-1:0] exp_prod = '0;

  mac_seq_multiplier_if #(.N(N)) bus ();

  mac_seq_multiplier #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cycle_cnt++;
    if (bus.done === 1'b1) done_pulses++;
  end

  // Reference product from plain arithmetic
  function automatic logic [2*N-1:0] ref_mul(input logic [N-1:0] a, input logic [N-1:0] b);
`ifdef MAC_MULT_SIGNED_EN
    logic signed [2*N-1:0] sa, sb;
    sa = $signed({{N{a[N-1]}}, a});
    sb = $signed({{N{b[N-1]}}, b});
    return sa * sb;
`else
    logic [2*N-1:0] ua, ub;
    ua = {{N{1'b0}}, a};
    ub = {{N{1'b0}}, b};
    return ua * ub;
`endif
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge while the DUT is idle; returns at the negedge of the
  // first IDLE cycle after done so a following call is back-to-back.
  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b,
                        input bit glitch, input string tag);
    int cyc;
    int busy_cnt;
    int pulses0;
    logic [2*N-1:0] exp;
    exp     = ref_mul(a, b);
    pulses0 = done_pulses;
    bus.start        = 1'b1;
    bus.multiplicand = a;
    bus.multiplier   = b;
    @(negedge clk);
    bus.start        = 1'b0;
    bus.multiplicand = $urandom;
    bus.multiplier   = $urandom;
    cyc      = 1;
    busy_cnt = 0;
    while (bus.done !== 1'b1 && cyc <= N + 4) begin
      if (bus.busy === 1'b1) busy_cnt++;
      if (cyc == 1 || cyc == N) check({tag, "_hold"}, bus.product, exp_prod);
      if (glitch && cyc == 10) begin
        bus.start        = 1'b1;
        bus.multiplicand = 5;
        bus.multiplier   = 5;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    bus.start = 1'b0;
    check({tag, "_latency"}, 64'(cyc), 64'(N + 1));
    check({tag, "_busycnt"}, 64'(busy_cnt), 64'(N));
    check({tag, "_busy_at_done"}, 64'(bus.busy), 64'd0);
    check({tag, "_product"}, bus.product, exp);
    last_done = cycle_cnt;
    exp_prod  = exp;
    @(negedge clk);
    check({tag, "_done_pulse"}, 64'(bus.done), 64'd0);
    check({tag, "_pulses"}, 64'(done_pulses - pulses0), 64'd1);
  endtask

  function automatic logic [N-1:0] rand_operand();
    int sel;
    sel = $urandom_range(0, 7);
    case (sel)
      0:       return '0;
      1:       return '1;
      2:       return {1'b1, {(N-1){1'b0}}};
      3:       return N'($urandom_range(0, 15));
      default: return N'($urandom);
    endcase
  endfunction

  initial begin
    int d1;
    int pulses0;
    rst              = 1'b1;
    bus.start        = 1'b0;
    bus.multiplicand = '0;
    bus.multiplier   = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", 64'(bus.busy), 64'd0);
    check("reset_done", 64'(bus.done), 64'd0);
    check("reset_product", bus.product, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Largest operands
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "max_x_max");
    // Zero operand: full iteration, prior product held until done
    run_op(32'h0000_0000, 32'h1234_5678, 1'b0, "zero");
    // Start during RUN ignored
    run_op(32'h0000_000A, 32'h0000_0007, 1'b1, "ignored_start");
    // Back-to-back operations
    run_op(32'd3, 32'd4, 1'b0, "b2b_first");
    d1 = last_done;
    run_op(32'h0001_0000, 32'h0001_0000, 1'b0, "b2b_second");
    check("b2b_spacing", 64'(last_done - d1), 64'(N + 2));

    // Asynchronous reset in the middle of RUN
    bus.start        = 1'b1;
    bus.multiplicand = 32'h1234_5678;
    bus.multiplier   = 32'h9ABC_DEF0;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (14) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_busy", 64'(bus.busy), 64'd0);
    check("midrst_done", 64'(bus.done), 64'd0);
    check("midrst_product", bus.product, 64'd0);
    @(negedge clk);
    rst      = 1'b0;
    pulses0  = done_pulses;
    exp_prod = '0;
    repeat (N + 4) @(negedge clk);
    check("midrst_no_done", 64'(done_pulses - pulses0), 64'd0);
    run_op(32'd2, 32'd3, 1'b0, "after_rst");

`ifdef MAC_MULT_SIGNED_EN
    run_op(32'hFFFF_FFFD, 32'h0000_0005, 1'b0, "signed_neg3x5");
    check("signed_neg3x5_const", exp_prod, 64'hFFFF_FFFF_FFFF_FFF1);
    run_op(32'h8000_0000, 32'h8000_0000, 1'b0, "signed_minxmin");
    check("signed_minxmin_const", exp_prod, 64'h4000_0000_0000_0000);
`endif

    // Randomized operands with random idle gaps
    for (int i = 0; i < 24; i++) begin
      int gap;
      gap = $urandom_range(0, 2);
      repeat (gap) @(negedge clk);
      run_op(rand_operand(), rand_operand(), bit'($urandom_range(0, 1)), "random");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
